// File: rtl/demux16x8_buffered.sv
// rtl/demux16x8_buffered.sv - registered 1-to-8 demux into single-entry holding slots
// Each slot drains independently; input stalls only on a full, undrained target slot.
module demux16x8_buffered #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  dataIn,
    input  logic [SEL_WIDTH-1:0]              selectInput,
    input  logic                              inValid,
    output logic                              inReady,
    output logic [(2**SEL_WIDTH)*WIDTH-1:0]   dataOut,
    output logic [(2**SEL_WIDTH)-1:0]         outValid,
    input  logic [(2**SEL_WIDTH)-1:0]         outReady,
    output logic [SEL_WIDTH:0]                pendingCount
);
    localparam int NUM_OUT = 2**SEL_WIDTH;

    logic [WIDTH-1:0]   r_data [NUM_OUT];
    logic [NUM_OUT-1:0] r_valid;
    logic [SEL_WIDTH:0] r_count;

    logic               w_accept;
    logic [NUM_OUT-1:0] w_valid_next;
    logic [SEL_WIDTH:0] w_count_next;

    assign inReady  = !reset && (!r_valid[selectInput] || outReady[selectInput]);
    assign w_accept = inValid && inReady;

    // A load on the same edge as a drain keeps the slot full with the new word.
    always_comb begin
        w_valid_next = r_valid & ~outReady;
        if (w_accept) begin
            w_valid_next[selectInput] = 1'b1;
        end
    end

    // Counting the next valid vector keeps pendingCount locked to popcount(outValid).
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_count_next = w_count_next + (SEL_WIDTH+1)'(w_valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            if (w_accept) begin
                r_data[selectInput] <= dataIn;
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_pack
        assign dataOut[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign outValid     = r_valid;
    assign pendingCount = r_count;

endmodule

// File: tb/tb_demux16x8_buffered.sv
// tb/tb_demux16x8_buffered.sv - table-driven and randomized checks for demux16x8_buffered
module tb_demux16x8_buffered;
    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  dataIn;
    logic [2:0]   selectInput;
    logic         inValid;
    logic         inReady;
    logic [127:0] dataOut;
    logic [7:0]   outValid;
    logic [7:0]   outReady;
    logic [3:0]   pendingCount;

    int errors = 0;
    int checks = 0;

    demux16x8_buffered #(.WIDTH(16), .SEL_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .selectInput(selectInput),
        .inValid(inValid), .inReady(inReady), .dataOut(dataOut), .outValid(outValid),
        .outReady(outReady), .pendingCount(pendingCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [2:0]  sel;
        logic [15:0] din;
        logic [7:0]  ordy;
        logic        exp_ir;
        logic [7:0]  exp_ov;
        logic [3:0]  exp_cnt;
        logic [2:0]  chk_slot;
        logic [15:0] exp_slot;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] slot(input int i);
        return dataOut[i*16 +: 16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic iv, input logic [2:0] sel, input logic [15:0] din,
                       input logic [7:0] ordy, input logic ir, input logic [7:0] ov,
                       input logic [3:0] cnt, input logic [2:0] cs, input logic [15:0] cd);
        vec_t v;
        v.rst = rst; v.iv = iv; v.sel = sel; v.din = din; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_cnt = cnt; v.chk_slot = cs; v.exp_slot = cd;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; inValid = v.iv; selectInput = v.sel; dataIn = v.din; outReady = v.ordy;
        #1;
        check($sformatf("v%0d inReady", idx), 32'(inReady), 32'(v.exp_ir));
        @(posedge clk);
        #1;
        check($sformatf("v%0d outValid", idx), 32'(outValid), 32'(v.exp_ov));
        check($sformatf("v%0d pendingCount", idx), 32'(pendingCount), 32'(v.exp_cnt));
        check($sformatf("v%0d slot%0d", idx, v.chk_slot), 32'(slot(int'(v.chk_slot))), 32'(v.exp_slot));
    endtask

    logic        m_valid [8];
    logic [15:0] m_data  [8];

    initial begin
        reset = 1'b1; inValid = 1'b0; selectInput = '0; dataIn = '0; outReady = '0;

        //  rst iv sel din       ordy   ir  ov     cnt slot data
        add(1, 1, 3, 16'hBEEF, 8'h00, 0, 8'h00, 0, 3, 16'h0000);
        add(0, 1, 5, 16'h1234, 8'h00, 1, 8'h20, 1, 5, 16'h1234);
        add(0, 1, 5, 16'h5678, 8'h00, 0, 8'h20, 1, 5, 16'h1234);
        add(0, 1, 5, 16'h5678, 8'h20, 1, 8'h20, 1, 5, 16'h5678);
        add(0, 1, 2, 16'h0007, 8'h00, 1, 8'h24, 2, 2, 16'h0007);
        add(0, 0, 0, 16'h0000, 8'h04, 1, 8'h20, 1, 2, 16'h0007);
        add(0, 0, 0, 16'h0000, 8'hA0, 1, 8'h00, 0, 5, 16'h5678);
        for (int i = 0; i < 8; i++)
            add(0, 1, 3'(i), 16'(i * 16'h1111), 8'h00, 1, 8'((1 << (i + 1)) - 1), 4'(i + 1), 3'(i), 16'(i * 16'h1111));
        add(0, 1, 3, 16'hFFFF, 8'h00, 0, 8'hFF, 8, 3, 16'h3333);

        for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

        // All slots full: every select must stall.
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            inValid = 1'b1; selectInput = 3'(s); outReady = 8'h00;
            #1;
            check($sformatf("full sel%0d inReady", s), 32'(inReady), 32'd0);
        end

        // Drain every slot at once; contents are left stale.
        @(negedge clk);
        inValid = 1'b0; outReady = 8'hFF;
        @(posedge clk); #1;
        check("drain_all outValid", 32'(outValid), 32'h00);
        check("drain_all pendingCount", 32'(pendingCount), 32'd0);
        for (int s = 0; s < 8; s++)
            check($sformatf("drain_all slot%0d", s), 32'(slot(s)), 32'(16'(s * 16'h1111)));

        // Mid-operation reset drops held words.
        vecs.delete();
        add(0, 1, 1, 16'hAAAA, 8'h00, 1, 8'h02, 1, 1, 16'hAAAA);
        add(1, 1, 1, 16'h5555, 8'h00, 0, 8'h00, 0, 1, 16'h0000);
        add(0, 1, 1, 16'h5555, 8'h00, 1, 8'h02, 1, 1, 16'h5555);
        add(1, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000);
        for (int k = 0; k < vecs.size(); k++) apply(vecs[k], 100 + k);

        // Random traffic against a single-entry per-slot scoreboard.
        for (int s = 0; s < 8; s++) begin m_valid[s] = 1'b0; m_data[s] = '0; end
        for (int c = 0; c < 10000; c++) begin
            logic exp_ir;
            logic [7:0] mv;
            int pc;
            @(negedge clk);
            reset = 1'b0;
            inValid = 1'($urandom_range(0, 1));
            selectInput = 3'($urandom_range(0, 7));
            dataIn = 16'($urandom);
            outReady = 8'($urandom);
            #1;
            mv = '0; pc = 0;
            for (int s = 0; s < 8; s++) begin mv[s] = m_valid[s]; pc += int'(m_valid[s]); end
            exp_ir = !m_valid[selectInput] || outReady[selectInput];
            check("rnd inReady", 32'(inReady), 32'(exp_ir));
            check("rnd outValid", 32'(outValid), 32'(mv));
            check("rnd pendingCount", 32'(pendingCount), 32'(pc));
            for (int s = 0; s < 8; s++) begin
                if (m_valid[s] && outReady[s]) begin
                    check($sformatf("rnd drain slot%0d", s), 32'(slot(s)), 32'(m_data[s]));
                    m_valid[s] = 1'b0;
                end
            end
            if (inValid && exp_ir) begin
                m_valid[selectInput] = 1'b1;
                m_data[selectInput] = dataIn;
            end
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
